dvr_chain_skid: RTL and testbench

- Parametrised elastic pipeline of NUM_SLOTS data-valid registers, with an optional skid slot at the head so ins_ready becomes a registered signal.
- Exposes a live occupancy count of tokens held in the block.
- Used in the handshake library wherever multi-cycle latency balancing is needed and the combinational ready path through a long chain would limit timing.

---
 rtl/dvr_chain_skid.sv | 139 +++++++++++++
 tb/tb_dvr_chain_skid.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvr_chain_skid.sv
// Elastic chain of data-valid registers with an optional head skid slot that
// registers ins_ready, plus a live count of the tokens held in the block.
module dvr_chain_skid #(
   parameter int unsigned DATA_TYPE   = 32,
   parameter int unsigned NUM_SLOTS   = 4,
   parameter int unsigned BREAK_READY = 1,
   parameter int unsigned OCC_WIDTH   = $clog2(NUM_SLOTS + 2)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_TYPE-1:0] ins,
   input  logic                 ins_valid,
   output logic                 ins_ready,
   output logic [DATA_TYPE-1:0] outs,
   output logic                 outs_valid,
   input  logic                 outs_ready,
   output logic [OCC_WIDTH-1:0] occupancy
);

   logic [NUM_SLOTS-1:0] slot_v_q;
   logic [DATA_TYPE-1:0] slot_d_q  [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] slot_rdy;
   logic [NUM_SLOTS-1:0] slot_in_v;
   logic [DATA_TYPE-1:0] slot_in_d [NUM_SLOTS];

   logic                 head_valid;
   logic [DATA_TYPE-1:0] head_data;
   logic                 skid_full;

   logic [OCC_WIDTH-1:0] occ_q;
   logic                 in_xfer;
   logic                 out_xfer;

   // A slot is ready if it or any slot downstream of it is empty, or the sink
   // is ready; accumulated from the output end so no vector bit feeds another.
   always_comb begin
      logic acc;
      acc      = outs_ready;
      slot_rdy = '0;
      for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
         acc         = acc | ~slot_v_q[i];
         slot_rdy[i] = acc;
      end
   end

   always_comb begin
      slot_in_v[0] = head_valid;
      slot_in_d[0] = head_data;
      for (int i = 1; i < int'(NUM_SLOTS); i++) begin
         slot_in_v[i] = slot_v_q[i-1];
         slot_in_d[i] = slot_d_q[i-1];
      end
   end

   generate
      if (BREAK_READY != 0) begin : g_skid
         logic                 skid_full_q;
         logic [DATA_TYPE-1:0] skid_data_q;

         // Park the incoming token only when the chain head refuses it.
         always_ff @(posedge clk) begin
            if (rst) begin
               skid_full_q <= 1'b0;
               skid_data_q <= '0;
            end else if (!skid_full_q && ins_valid && !slot_rdy[0]) begin
               skid_full_q <= 1'b1;
               skid_data_q <= ins;
            end else if (skid_full_q && slot_rdy[0]) begin
               skid_full_q <= 1'b0;
            end
         end

         assign skid_full  = skid_full_q;
         assign head_valid = skid_full_q | ins_valid;
         assign head_data  = skid_full_q ? skid_data_q : ins;
         assign ins_ready  = ~skid_full_q;
      end else begin : g_no_skid
         assign skid_full  = 1'b0;
         assign head_valid = ins_valid;
         assign head_data  = ins;
         assign ins_ready  = slot_rdy[0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_v_q <= '0;
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            slot_d_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (slot_rdy[i]) begin
               slot_v_q[i] <= slot_in_v[i];
               if (slot_in_v[i]) begin
                  slot_d_q[i] <= slot_in_d[i];
               end
            end
         end
      end
   end

   assign in_xfer  = ins_valid & ins_ready;
   assign out_xfer = outs_valid & outs_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else if (in_xfer && !out_xfer) begin
         occ_q <= occ_q + OCC_WIDTH'(1);
      end else if (!in_xfer && out_xfer) begin
         occ_q <= occ_q - OCC_WIDTH'(1);
      end
   end

   assign occupancy  = occ_q;
   assign outs       = slot_d_q[NUM_SLOTS-1];
   assign outs_valid = slot_v_q[NUM_SLOTS-1];

   logic [OCC_WIDTH-1:0] held_cnt;

   always_comb begin
      held_cnt = OCC_WIDTH'(skid_full);
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         held_cnt = held_cnt + OCC_WIDTH'(slot_v_q[i]);
      end
   end

   // The running count must always agree with what is physically held.
   a_occ_matches_held: assert property (@(posedge clk) disable iff (rst)
      occ_q == held_cnt);

   a_occ_bounded: assert property (@(posedge clk) disable iff (rst)
      int'(occ_q) <= int'(NUM_SLOTS + BREAK_READY));

   a_outs_stable: assert property (@(posedge clk) disable iff (rst)
      (outs_valid && !outs_ready) |=> (outs_valid && $stable(outs)));

endmodule

// File: tb/tb_dvr_chain_skid.sv
// Bench for dvr_chain_skid: directed scenarios on two configurations and a
// randomised scoreboard run on four more.
module tb_dvr_chain_skid;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // DUT A: 32-bit, 4 slots, skid
   logic [31:0] a_ins  = '0;
   logic        a_iv   = 1'b0;
   logic        a_ir;
   logic [31:0] a_outs;
   logic        a_ov;
   logic        a_or   = 1'b0;
   logic [2:0]  a_occ;

   // DUT B: 8-bit, 2 slots, combinational ready
   logic [7:0]  b_ins  = '0;
   logic        b_iv   = 1'b0;
   logic        b_ir;
   logic [7:0]  b_outs;
   logic        b_ov;
   logic        b_or   = 1'b0;
   logic [1:0]  b_occ;

   // Random DUTs: (slots, skid) = (1,1) (3,1) (8,1) (3,0)
   logic [7:0]  r_ins  [4];
   logic        r_iv   [4];
   logic        r_ir   [4];
   logic [7:0]  r_outs [4];
   logic        r_ov   [4];
   logic        r_or   [4];
   logic [3:0]  r_occ  [4];
   logic [1:0]  r0_occ;
   logic [2:0]  r1_occ;
   logic [3:0]  r2_occ;
   logic [2:0]  r3_occ;

   assign r_occ[0] = {2'b00, r0_occ};
   assign r_occ[1] = {1'b0, r1_occ};
   assign r_occ[2] = r2_occ;
   assign r_occ[3] = {1'b0, r3_occ};

   dvr_chain_skid #(.DATA_TYPE(32), .NUM_SLOTS(4), .BREAK_READY(1)) u_a (
      .clk(clk), .rst(rst), .ins(a_ins), .ins_valid(a_iv), .ins_ready(a_ir),
      .outs(a_outs), .outs_valid(a_ov), .outs_ready(a_or), .occupancy(a_occ));

   dvr_chain_skid #(.DATA_TYPE(8), .NUM_SLOTS(2), .BREAK_READY(0)) u_b (
      .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_iv), .ins_ready(b_ir),
      .outs(b_outs), .outs_valid(b_ov), .outs_ready(b_or), .occupancy(b_occ));

   dvr_chain_skid #(.DATA_TYPE(8), .NUM_SLOTS(1), .BREAK_READY(1)) u_r0 (
      .clk(clk), .rst(rst), .ins(r_ins[0]), .ins_valid(r_iv[0]), .ins_ready(r_ir[0]),
      .outs(r_outs[0]), .outs_valid(r_ov[0]), .outs_ready(r_or[0]), .occupancy(r0_occ));

   dvr_chain_skid #(.DATA_TYPE(8), .NUM_SLOTS(3), .BREAK_READY(1)) u_r1 (
      .clk(clk), .rst(rst), .ins(r_ins[1]), .ins_valid(r_iv[1]), .ins_ready(r_ir[1]),
      .outs(r_outs[1]), .outs_valid(r_ov[1]), .outs_ready(r_or[1]), .occupancy(r1_occ));

   dvr_chain_skid #(.DATA_TYPE(8), .NUM_SLOTS(8), .BREAK_READY(1)) u_r2 (
      .clk(clk), .rst(rst), .ins(r_ins[2]), .ins_valid(r_iv[2]), .ins_ready(r_ir[2]),
      .outs(r_outs[2]), .outs_valid(r_ov[2]), .outs_ready(r_or[2]), .occupancy(r2_occ));

   dvr_chain_skid #(.DATA_TYPE(8), .NUM_SLOTS(3), .BREAK_READY(0)) u_r3 (
      .clk(clk), .rst(rst), .ins(r_ins[3]), .ins_valid(r_iv[3]), .ins_ready(r_ir[3]),
      .outs(r_outs[3]), .outs_valid(r_ov[3]), .outs_ready(r_or[3]), .occupancy(r3_occ));

   task automatic test_reset();
      rst = 1'b1;
      a_iv = 1'b1; a_ins = 32'hDEAD_BEEF; a_or = 1'b1;
      b_iv = 1'b1; b_ins = 8'hEE;         b_or = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      a_iv = 1'b0; a_or = 1'b0;
      b_iv = 1'b0; b_or = 1'b0;
      #1;
      total++; if (a_ov !== 1'b0) $display("FAIL reset_a_outs_valid got %b want 0", a_ov); else passed++;
      total++; if (a_outs !== 32'h0) $display("FAIL reset_a_outs got %h want 0", a_outs); else passed++;
      total++; if (a_occ !== 3'd0) $display("FAIL reset_a_occ got %0d want 0", a_occ); else passed++;
      total++; if (a_ir !== 1'b1) $display("FAIL reset_a_ins_ready got %b want 1", a_ir); else passed++;
      total++; if (b_ov !== 1'b0) $display("FAIL reset_b_outs_valid got %b want 0", b_ov); else passed++;
      total++; if (b_outs !== 8'h0) $display("FAIL reset_b_outs got %h want 0", b_outs); else passed++;
      total++; if (b_occ !== 2'd0) $display("FAIL reset_b_occ got %0d want 0", b_occ); else passed++;
      total++; if (b_ir !== 1'b1) $display("FAIL reset_b_ins_ready got %b want 1", b_ir); else passed++;
   endtask

   task automatic test_streaming();
      int acc_n;
      int del_n;
      logic exp_ov;
      a_or = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         a_iv  = (c < 8);
         a_ins = 32'(16 + c);
         #1;
         acc_n  = (c < 8) ? c : 8;
         del_n  = (c < 4) ? 0 : ((c - 4 > 8) ? 8 : c - 4);
         exp_ov = (c >= 4) && (c < 12);
         total++; if (a_ir !== 1'b1) $display("FAIL stream_ready c=%0d got %b want 1", c, a_ir); else passed++;
         total++; if (a_ov !== exp_ov) $display("FAIL stream_valid c=%0d got %b want %b", c, a_ov, exp_ov); else passed++;
         if (exp_ov) begin
            total++;
            if (a_outs !== 32'(16 + c - 4)) $display("FAIL stream_data c=%0d got %h want %h", c, a_outs, 32'(16 + c - 4));
            else passed++;
         end
         total++;
         if (a_occ !== 3'(acc_n - del_n)) $display("FAIL stream_occ c=%0d got %0d want %0d", c, a_occ, acc_n - del_n);
         else passed++;
      end
      a_iv = 1'b0;
   endtask

   task automatic test_fill();
      int acc_n = 0;
      a_or = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         a_iv  = 1'b1;
         a_ins = 32'(160 + acc_n);
         #1;
         total++; if (a_ir !== (acc_n < 5)) $display("FAIL fill_ready c=%0d got %b want %b", c, a_ir, acc_n < 5); else passed++;
         total++; if (a_occ !== 3'(acc_n)) $display("FAIL fill_occ c=%0d got %0d want %0d", c, a_occ, acc_n); else passed++;
         if (c >= 4) begin
            total++; if (a_ov !== 1'b1) $display("FAIL fill_valid c=%0d got %b want 1", c, a_ov); else passed++;
            total++; if (a_outs !== 32'hA0) $display("FAIL fill_hold c=%0d got %h want a0", c, a_outs); else passed++;
         end
         if (a_iv && a_ir) acc_n++;
      end
      total++; if (acc_n != 5) $display("FAIL fill_accepts got %0d want 5", acc_n); else passed++;
      @(negedge clk);
      a_iv = 1'b0;
      a_or = 1'b1;
      #1;
      total++; if (a_ir !== 1'b0) $display("FAIL drain_ready_first got %b want 0", a_ir); else passed++;
      for (int j = 0; j < 6; j++) begin
         if (j > 0) begin
            @(negedge clk);
            #1;
         end
         if (j == 1) begin
            total++; if (a_ir !== 1'b1) $display("FAIL drain_ready_back got %b want 1", a_ir); else passed++;
         end
         total++; if (a_ov !== (j < 5)) $display("FAIL drain_valid j=%0d got %b want %b", j, a_ov, j < 5); else passed++;
         if (j < 5) begin
            total++;
            if (a_outs !== 32'(160 + j)) $display("FAIL drain_data j=%0d got %h want %h", j, a_outs, 32'(160 + j));
            else passed++;
         end
         total++; if (a_occ !== 3'(5 - j)) $display("FAIL drain_occ j=%0d got %0d want %0d", j, a_occ, 5 - j); else passed++;
      end
      a_or = 1'b0;
   endtask

   task automatic test_bubble();
      a_or = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         a_iv  = (c == 0) || (c == 3);
         a_ins = (c == 0) ? 32'h1 : 32'h2;
         #1;
         total++; if (a_ir !== 1'b1) $display("FAIL bubble_ready c=%0d got %b want 1", c, a_ir); else passed++;
      end
      a_iv = 1'b0;
      total++; if (a_occ !== 3'd2) $display("FAIL bubble_occ got %0d want 2", a_occ); else passed++;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         a_or = 1'b1;
         #1;
         total++; if (a_ov !== (j < 2)) $display("FAIL bubble_valid j=%0d got %b want %b", j, a_ov, j < 2); else passed++;
         if (j < 2) begin
            total++;
            if (a_outs !== 32'(j + 1)) $display("FAIL bubble_data j=%0d got %h want %h", j, a_outs, 32'(j + 1));
            else passed++;
         end
      end
      a_or = 1'b0;
   endtask

   task automatic test_reset_mid();
      a_or = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         a_iv  = (c < 3);
         a_ins = 32'(49 + c);
         #1;
      end
      a_iv = 1'b0;
      total++; if (a_occ !== 3'd3) $display("FAIL rmid_occ_before got %0d want 3", a_occ); else passed++;
      total++; if (a_ov !== 1'b1) $display("FAIL rmid_valid_before got %b want 1", a_ov); else passed++;
      @(negedge clk);
      rst = 1'b1; a_or = 1'b1; a_iv = 1'b1; a_ins = 32'h99;
      #1;
      @(negedge clk);
      rst = 1'b0; a_iv = 1'b1; a_ins = 32'h55;
      #1;
      total++; if (a_ov !== 1'b0) $display("FAIL rmid_valid_after got %b want 0", a_ov); else passed++;
      total++; if (a_occ !== 3'd0) $display("FAIL rmid_occ_after got %0d want 0", a_occ); else passed++;
      total++; if (a_ir !== 1'b1) $display("FAIL rmid_ready_after got %b want 1", a_ir); else passed++;
      for (int j = 1; j < 6; j++) begin
         @(negedge clk);
         a_iv = 1'b0;
         #1;
         total++; if (a_ov !== (j == 4)) $display("FAIL rmid_valid j=%0d got %b want %b", j, a_ov, j == 4); else passed++;
         if (j == 4) begin
            total++; if (a_outs !== 32'h55) $display("FAIL rmid_data got %h want 55", a_outs); else passed++;
         end
         total++;
         if (a_occ !== ((j < 5) ? 3'd1 : 3'd0)) $display("FAIL rmid_occ j=%0d got %0d want %0d", j, a_occ, (j < 5) ? 1 : 0);
         else passed++;
      end
      a_or = 1'b0;
   endtask

   task automatic test_comb_ready();
      b_or = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         b_iv  = 1'b1;
         b_ins = 8'(97 + c);
         #1;
         total++; if (b_ir !== 1'b1) $display("FAIL comb_fill_ready c=%0d got %b want 1", c, b_ir); else passed++;
      end
      @(negedge clk);
      b_iv = 1'b1; b_ins = 8'h63; b_or = 1'b0;
      #1;
      total++; if (b_ir !== 1'b0) $display("FAIL comb_full_ready got %b want 0", b_ir); else passed++;
      total++; if (b_occ !== 2'd2) $display("FAIL comb_full_occ got %0d want 2", b_occ); else passed++;
      total++; if (b_ov !== 1'b1 || b_outs !== 8'h61) $display("FAIL comb_full_out got %b/%h want 1/61", b_ov, b_outs); else passed++;
      b_or = 1'b1;
      #1;
      total++; if (b_ir !== 1'b1) $display("FAIL comb_same_cycle_ready got %b want 1", b_ir); else passed++;
      @(negedge clk);
      b_iv = 1'b0; b_or = 1'b0;
      #1;
      total++; if (b_occ !== 2'd2) $display("FAIL comb_swap_occ got %0d want 2", b_occ); else passed++;
      total++; if (b_ir !== 1'b0) $display("FAIL comb_refull_ready got %b want 0", b_ir); else passed++;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         b_or = 1'b1;
         #1;
         total++; if (b_ov !== (j < 2)) $display("FAIL comb_drain_valid j=%0d got %b want %b", j, b_ov, j < 2); else passed++;
         if (j < 2) begin
            total++;
            if (b_outs !== 8'(98 + j)) $display("FAIL comb_drain_data j=%0d got %h want %h", j, b_outs, 8'(98 + j));
            else passed++;
         end
         total++; if (b_occ !== 2'(2 - j)) $display("FAIL comb_drain_occ j=%0d got %0d want %0d", j, b_occ, 2 - j); else passed++;
      end
      b_or = 1'b0;
   endtask

   task automatic test_random();
      int   nsl [4] = '{1, 3, 8, 3};
      int   cap [4] = '{2, 4, 9, 3};
      bit   skid[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0] sbq [4][$];
      bit   prev_stall [4];
      logic [7:0] prev_outs [4];
      int   cnt;
      logic exp_ir;
      logic [7:0] want;
      for (int k = 0; k < 4; k++) begin
         r_iv[k] = 1'b0; r_or[k] = 1'b0; r_ins[k] = '0;
         sbq[k].delete();
         prev_stall[k] = 1'b0;
         prev_outs[k]  = '0;
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (cyc > 0) @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            r_iv[k]  = 1'($urandom_range(0, 1));
            r_or[k]  = 1'($urandom_range(0, 1));
            r_ins[k] = 8'($urandom);
         end
         #1;
         for (int k = 0; k < 4; k++) begin
            cnt = sbq[k].size();
            total++;
            if (r_occ[k] !== 4'(cnt)) $display("FAIL rnd_occ k=%0d cyc=%0d got %0d want %0d", k, cyc, r_occ[k], cnt);
            else passed++;
            exp_ir = skid[k] ? (cnt != cap[k]) : !((cnt == nsl[k]) && !r_or[k]);
            total++;
            if (r_ir[k] !== exp_ir) $display("FAIL rnd_ready k=%0d cyc=%0d got %b want %b", k, cyc, r_ir[k], exp_ir);
            else passed++;
            if (cnt == 0) begin
               total++;
               if (r_ov[k] !== 1'b0) $display("FAIL rnd_empty_valid k=%0d cyc=%0d got %b want 0", k, cyc, r_ov[k]);
               else passed++;
            end
            if (prev_stall[k]) begin
               total++;
               if (r_ov[k] !== 1'b1 || r_outs[k] !== prev_outs[k])
                  $display("FAIL rnd_stall k=%0d cyc=%0d got %b/%h want 1/%h", k, cyc, r_ov[k], r_outs[k], prev_outs[k]);
               else passed++;
            end
            if (r_ov[k] === 1'b1 && r_or[k]) begin
               want = (cnt > 0) ? sbq[k][0] : 8'hxx;
               total++;
               if (cnt == 0 || r_outs[k] !== want)
                  $display("FAIL rnd_order k=%0d cyc=%0d got %h want %h (queued %0d)", k, cyc, r_outs[k], want, cnt);
               else passed++;
               if (cnt > 0) void'(sbq[k].pop_front());
            end
            if (r_iv[k] && r_ir[k] === 1'b1) sbq[k].push_back(r_ins[k]);
            prev_stall[k] = (r_ov[k] === 1'b1) && !r_or[k];
            prev_outs[k]  = r_outs[k];
         end
      end
      for (int k = 0; k < 4; k++) begin
         r_iv[k] = 1'b0; r_or[k] = 1'b0;
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         r_iv[k] = 1'b0; r_or[k] = 1'b0; r_ins[k] = '0;
      end
      test_reset();
      test_streaming();
      test_fill();
      test_bubble();
      test_reset_mid();
      test_comb_ready();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
